// File: rtl/axi_stream_pkt_arb_if.sv
// ---------------------------------------------------------------------------
// if_axi_stream
// Bundles one AXI-stream style beat channel: valid/ready handshake plus the
// data, control sideband, byte-modulo and packet framing fields.
//
// Parameters
//   DAT_BITS - data width per beat
//   MOD_BITS - width of the byte-modulo field
//   CTL_BITS - width of the sideband control field
//
// Modports
//   slave  - the side that sources beats (drives val/dat/ctl/mod/sop/eop/err,
//            obeys rdy); the packet arbiter's merged output uses this one
//   master - the downstream sink (observes the beat fields, drives rdy)
// ---------------------------------------------------------------------------
interface if_axi_stream #(
    parameter int DAT_BITS = 64,
    parameter int MOD_BITS = 3,
    parameter int CTL_BITS = 8
) ();

    logic                val;
    logic                rdy;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;
    logic                sop;
    logic                eop;
    logic                err;

    modport slave (
        output val, dat, ctl, mod, sop, eop, err,
        input  rdy
    );

    modport master (
        input  val, dat, ctl, mod, sop, eop, err,
        output rdy
    );

endinterface

// File: rtl/axi_stream_pkt_arb.sv
// ---------------------------------------------------------------------------
// axi_stream_pkt_arb
// Round-robin packet arbiter merging NUM_IN beat streams onto one output.
// Once a multi-beat packet wins, the output stays locked to that requester
// until its eop beat transfers, so packets are never interleaved. The
// datapath is a pure combinational mux (zero latency); only the arbitration
// state (IDLE/LOCKED, rr_ptr, lock_idx) is registered.
//
// Parameters
//   NUM_IN   - number of requester streams (2..16)
//   DAT_BITS - data width per beat
//   MOD_BITS - width of the byte-modulo field
//   CTL_BITS - width of the sideband control field
//
// Ports
//   i_clk    - clock, all state changes on its rising edge
//   i_rst    - synchronous active-high reset
//   i_val    - per-requester beat valid
//   o_rdy_in - per-requester ready (output ready routed to the granted one)
//   i_dat    - requester k data at [k*DAT_BITS +: DAT_BITS]
//   i_ctl    - requester k control at [k*CTL_BITS +: CTL_BITS]
//   i_mod    - requester k modulo at [k*MOD_BITS +: MOD_BITS]
//   i_sop    - per-requester start-of-packet
//   i_eop    - per-requester end-of-packet
//   i_err    - per-requester error flag
//   o_axi    - merged output stream
//   o_grant  - one-hot selected requester, zero when none
//   o_lock   - high while a multi-beat packet owns the output
// ---------------------------------------------------------------------------
module axi_stream_pkt_arb #(
    parameter int NUM_IN   = 4,
    parameter int DAT_BITS = 64,
    parameter int MOD_BITS = $clog2(DAT_BITS / 8),
    parameter int CTL_BITS = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_IN-1:0]            i_val,
    output logic [NUM_IN-1:0]            o_rdy_in,
    input  logic [NUM_IN*DAT_BITS-1:0]   i_dat,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_ctl,
    input  logic [NUM_IN*MOD_BITS-1:0]   i_mod,
    input  logic [NUM_IN-1:0]            i_sop,
    input  logic [NUM_IN-1:0]            i_eop,
    input  logic [NUM_IN-1:0]            i_err,
    if_axi_stream.slave                  o_axi,
    output logic [NUM_IN-1:0]            o_grant,
    output logic                         o_lock
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          rr_ptr_q, rr_ptr_d;
    logic [3:0]          lock_idx_q, lock_idx_d;

    logic [NUM_IN-1:0]   grant;
    logic [3:0]          gnt_idx;
    logic                beaten;

    logic                sel_val;
    logic [DAT_BITS-1:0] sel_dat;
    logic [CTL_BITS-1:0] sel_ctl;
    logic [MOD_BITS-1:0] sel_mod;
    logic                sel_sop;
    logic                sel_eop;
    logic                sel_err;
    logic                xfer;

    // Distance of requester k from the round-robin pointer, walking upward
    // with wrap; the smallest distance among valid requesters wins.
    function automatic int rr_dist(input int k, input logic [3:0] ptr);
        int d;
        d = k - int'(ptr);
        if (d < 0) begin
            d = d + NUM_IN;
        end
        return d;
    endfunction

    function automatic logic [3:0] next_idx(input logic [3:0] idx);
        return (idx >= 4'(NUM_IN - 1)) ? 4'd0 : idx + 4'd1;
    endfunction

    // Grant selection. Each requester is granted when it is valid and no
    // other valid requester sits closer to rr_ptr, giving a one-hot result
    // without any variable indexing. Reset forces the grant to zero, which
    // in turn zeroes o_axi.val and o_rdy_in.
    always_comb begin
        grant  = '0;
        beaten = 1'b0;
        if (state_q == ST_LOCKED) begin
            for (int k = 0; k < NUM_IN; k++) begin
                grant[k] = (lock_idx_q == 4'(k));
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                beaten = 1'b0;
                for (int j = 0; j < NUM_IN; j++) begin
                    if ((j != k) && i_val[j] && (rr_dist(j, rr_ptr_q) < rr_dist(k, rr_ptr_q))) begin
                        beaten = 1'b1;
                    end
                end
                grant[k] = i_val[k] && !beaten;
            end
        end
        if (i_rst) begin
            grant = '0;
        end
    end

    // Zero-latency field mux driven by the one-hot grant.
    always_comb begin
        gnt_idx = 4'd0;
        sel_dat = '0;
        sel_ctl = '0;
        sel_mod = '0;
        sel_sop = 1'b0;
        sel_eop = 1'b0;
        sel_err = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant[k]) begin
                gnt_idx = 4'(k);
                sel_dat = i_dat[k*DAT_BITS +: DAT_BITS];
                sel_ctl = i_ctl[k*CTL_BITS +: CTL_BITS];
                sel_mod = i_mod[k*MOD_BITS +: MOD_BITS];
                sel_sop = i_sop[k];
                sel_eop = i_eop[k];
                sel_err = i_err[k];
            end
        end
    end

    assign sel_val   = |(grant & i_val);
    assign xfer      = sel_val && o_axi.rdy;

    assign o_axi.val = sel_val;
    assign o_axi.dat = sel_dat;
    assign o_axi.ctl = sel_ctl;
    assign o_axi.mod = sel_mod;
    assign o_axi.sop = sel_sop;
    assign o_axi.eop = sel_eop;
    assign o_axi.err = sel_err;

    assign o_rdy_in  = grant & {NUM_IN{o_axi.rdy}};
    assign o_grant   = grant;
    assign o_lock    = (state_q == ST_LOCKED) && !i_rst;

    // Only a completed transfer commits arbitration state: a non-eop beat
    // in IDLE locks onto its owner, an eop beat releases and advances rr_ptr
    // past the requester that just finished.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (sel_eop) begin
                        rr_ptr_d = next_idx(gnt_idx);
                    end else begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = gnt_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_eop) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(lock_idx_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 4'd0;
            lock_idx_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_pkt_arb.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_pkt_arb
// Directed bench for axi_stream_pkt_arb with NUM_IN=4, DAT_BITS=64.
// Each requester's data carries its index and a running beat number so a
// lost or duplicated beat shows up as a wrong data value on the output.
// ---------------------------------------------------------------------------
module tb_axi_stream_pkt_arb;

    localparam int NUM_IN   = 4;
    localparam int DAT_BITS = 64;
    localparam int MOD_BITS = 3;
    localparam int CTL_BITS = 8;

    logic                       i_clk;
    logic                       i_rst;
    logic [NUM_IN-1:0]          i_val;
    logic [NUM_IN-1:0]          o_rdy_in;
    logic [NUM_IN*DAT_BITS-1:0] i_dat;
    logic [NUM_IN*CTL_BITS-1:0] i_ctl;
    logic [NUM_IN*MOD_BITS-1:0] i_mod;
    logic [NUM_IN-1:0]          i_sop;
    logic [NUM_IN-1:0]          i_eop;
    logic [NUM_IN-1:0]          i_err;
    logic [NUM_IN-1:0]          o_grant;
    logic                       o_lock;

    int testsRun;
    int failCount;
    int beatNo [NUM_IN];

    if_axi_stream #(
        .DAT_BITS(DAT_BITS),
        .MOD_BITS(MOD_BITS),
        .CTL_BITS(CTL_BITS)
    ) axi ();

    axi_stream_pkt_arb #(
        .NUM_IN  (NUM_IN),
        .DAT_BITS(DAT_BITS),
        .MOD_BITS(MOD_BITS),
        .CTL_BITS(CTL_BITS)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_val   (i_val),
        .o_rdy_in(o_rdy_in),
        .i_dat   (i_dat),
        .i_ctl   (i_ctl),
        .i_mod   (i_mod),
        .i_sop   (i_sop),
        .i_eop   (i_eop),
        .i_err   (i_err),
        .o_axi   (axi),
        .o_grant (o_grant),
        .o_lock  (o_lock)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] beatData(input int k);
        return {32'(k), 32'(beatNo[k])};
    endfunction

    function automatic logic [7:0] beatCtl(input int k);
        return 8'h10 + 8'(k);
    endfunction

    function automatic logic [2:0] beatMod(input int k);
        return 3'(k + beatNo[k]);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] val, input logic [3:0] sop,
                                 input logic [3:0] eop, input logic [3:0] err, input logic rdy);
        i_rst   = rst;
        i_val   = val;
        i_sop   = sop;
        i_eop   = eop;
        i_err   = err;
        axi.rdy = rdy;
        for (int k = 0; k < NUM_IN; k++) begin
            i_dat[k*DAT_BITS +: DAT_BITS] = beatData(k);
            i_ctl[k*CTL_BITS +: CTL_BITS] = beatCtl(k);
            i_mod[k*MOD_BITS +: MOD_BITS] = beatMod(k);
        end
    endtask

    // One clock cycle: drive, let the combinational outputs settle, check
    // them against the hand-computed grant/lock, then advance the clock.
    task automatic runCycle(input string tag, input logic rst, input logic [3:0] val,
                            input logic [3:0] sop, input logic [3:0] eop, input logic [3:0] err,
                            input logic rdy, input logic [3:0] expGrant, input logic expLock);
        int   gi;
        logic expVal;
        applyStimulus(rst, val, sop, eop, err, rdy);
        #2;
        gi = -1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (expGrant[k]) gi = k;
        end
        expVal = (gi >= 0) ? val[gi] : 1'b0;
        checkOutput({tag, ".grant"}, 64'(o_grant), 64'(expGrant));
        checkOutput({tag, ".lock"}, 64'(o_lock), 64'(expLock));
        checkOutput({tag, ".val"}, 64'(axi.val), 64'(expVal));
        checkOutput({tag, ".rdyIn"}, 64'(o_rdy_in), 64'(rdy ? expGrant : 4'b0000));
        if (gi >= 0 && expVal) begin
            checkOutput({tag, ".dat"}, axi.dat, beatData(gi));
            checkOutput({tag, ".ctl"}, 64'(axi.ctl), 64'(beatCtl(gi)));
            checkOutput({tag, ".mod"}, 64'(axi.mod), 64'(beatMod(gi)));
            checkOutput({tag, ".sop"}, 64'(axi.sop), 64'(sop[gi]));
            checkOutput({tag, ".eop"}, 64'(axi.eop), 64'(eop[gi]));
            checkOutput({tag, ".err"}, 64'(axi.err), 64'(err[gi]));
            if (!rst && rdy) beatNo[gi]++;
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        for (int k = 0; k < NUM_IN; k++) beatNo[k] = 0;

        // Reset holds every output quiet even with all requesters valid
        runCycle("rst0", 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b0);
        runCycle("rst1", 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b0);

        // Fairness with single-beat packets, rr_ptr wraps 3 -> 0
        runCycle("fair0", 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b0);
        runCycle("fair1", 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 4'b0010, 1'b0);
        runCycle("fair2", 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 4'b0100, 1'b0);
        runCycle("fair3", 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 4'b1000, 1'b0);
        runCycle("fair4", 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b0);
        runCycle("fair5", 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 4'b0010, 1'b0);

        // No requesters, then grant floats with rdy=0 (rr_ptr=2)
        runCycle("none", 1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0);
        runCycle("flt0", 1'b0, 4'b0011, 4'hF, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b0);
        runCycle("flt1", 1'b0, 4'b0110, 4'hF, 4'hF, 4'h0, 1'b0, 4'b0100, 1'b0);
        runCycle("sgl", 1'b0, 4'b0001, 4'hF, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b0);

        // 3-beat packet from req1 with req0/req2 also valid, rr_ptr=1
        runCycle("lk1", 1'b0, 4'b0111, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0);
        runCycle("lk2", 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0010, 1'b1, 4'b0010, 1'b1);
        runCycle("lk3", 1'b0, 4'b0111, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1);
        runCycle("lkNext", 1'b0, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b0);

        // Backpressure then a bubble inside a req3 packet, rr_ptr=3
        runCycle("bp0", 1'b0, 4'b1011, 4'b1000, 4'b0000, 4'h0, 1'b1, 4'b1000, 1'b0);
        runCycle("bp1", 1'b0, 4'b1011, 4'b0000, 4'b0000, 4'h0, 1'b0, 4'b1000, 1'b1);
        runCycle("bp2", 1'b0, 4'b1011, 4'b0000, 4'b0000, 4'h0, 1'b0, 4'b1000, 1'b1);
        runCycle("bp3", 1'b0, 4'b1011, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b1000, 1'b1);
        runCycle("bub", 1'b0, 4'b0011, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b1000, 1'b1);
        runCycle("bpEnd", 1'b0, 4'b1011, 4'b0000, 4'b1000, 4'h0, 1'b1, 4'b1000, 1'b1);

        // Reset after beat 2 of a req3 packet; req0 must then win from rr_ptr=0
        runCycle("rs1", 1'b0, 4'b1000, 4'b1000, 4'b0000, 4'h0, 1'b1, 4'b1000, 1'b0);
        runCycle("rs2", 1'b0, 4'b1000, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b1000, 1'b1);
        runCycle("rsOn", 1'b1, 4'b1001, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b0000, 1'b0);
        runCycle("rsWin", 1'b0, 4'b1001, 4'b1001, 4'b1001, 4'h0, 1'b1, 4'b0001, 1'b0);
        runCycle("rsNext", 1'b0, 4'b1001, 4'b1001, 4'b1001, 4'h0, 1'b1, 4'b1000, 1'b0);

        // Sparse: only req2 valid, rr_ptr settles at 3 after each beat
        runCycle("sp0", 1'b0, 4'b0100, 4'b0100, 4'b0100, 4'h0, 1'b1, 4'b0100, 1'b0);
        runCycle("sp1", 1'b0, 4'b0100, 4'b0100, 4'b0100, 4'h0, 1'b1, 4'b0100, 1'b0);
        runCycle("sp2", 1'b0, 4'b0100, 4'b0100, 4'b0100, 4'h0, 1'b1, 4'b0100, 1'b0);
        runCycle("spChk", 1'b0, 4'b1100, 4'b1100, 4'b1100, 4'h0, 1'b1, 4'b1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/axi_stream_pkt_arb.md
AXI_STREAM_PKT_ARB -- requirements
Module: axi_stream_pkt_arb

Interface
REQ-001 Parameter NUM_IN, default 4, meaning number of requester streams; SHALL be 2..16.
REQ-002 Parameter DAT_BITS, default 64, meaning data width per beat.
REQ-003 Parameter MOD_BITS, default $clog2(DAT_BITS/8), meaning width of the byte-modulo field.
REQ-004 Parameter CTL_BITS, default 8, meaning width of the sideband control field.
REQ-005 Port i_clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-006 Port i_rst  input  1  synchronous, active-high reset.
REQ-007 Port i_val  input  NUM_IN  per-requester beat valid.
REQ-008 Port o_rdy_in  output  NUM_IN  per-requester ready.
REQ-009 Port i_dat  input  NUM_IN*DAT_BITS  requester k data at [k*DAT_BITS +: DAT_BITS].
REQ-010 Port i_ctl  input  NUM_IN*CTL_BITS  per-requester ctl, packed as i_dat.
REQ-011 Port i_mod  input  NUM_IN*MOD_BITS  per-requester mod, packed as i_dat.
REQ-012 Port i_sop, i_eop, i_err  input  NUM_IN each  per-requester framing bits.
REQ-013 Port o_axi  if_axi_stream.slave  --  merged output stream (val, rdy, dat, ctl, mod, sop, eop, err).
REQ-014 Port o_grant  output  NUM_IN  one-hot requester currently selected; all-zero when none.
REQ-015 Port o_lock  output  1  high while a multi-beat packet owns the output.

Function
REQ-016 Transfer on a port SHALL occur in a cycle where its val and rdy are both high.
REQ-017 Datapath SHALL be combinational, with zero latency: o_axi.dat/ctl/mod/sop/eop/err SHALL equal the granted requester's fields.
REQ-018 o_axi.val SHALL equal i_val of the granted requester, or 0 when o_grant is 0.
REQ-019 o_rdy_in[k] SHALL equal o_axi.rdy when o_grant[k] is 1; otherwise it SHALL be 0.
REQ-020 State machine SHALL have two states: IDLE and LOCKED. A 4-bit rr_ptr and a registered lock_idx SHALL hold the arbitration state.
REQ-021 In IDLE, o_grant SHALL select the first k with i_val[k]=1, searching k = rr_ptr, rr_ptr+1, ... modulo NUM_IN.
REQ-022 In IDLE, a transfer with eop=0 SHALL record lock_idx = the granted index and enter LOCKED.
REQ-023 In IDLE, a transfer with eop=1 (single-beat packet) SHALL stay in IDLE and set rr_ptr = (granted+1) mod NUM_IN.
REQ-024 In LOCKED, o_grant SHALL be one-hot at lock_idx regardless of other i_val; o_lock SHALL be 1.
REQ-025 In LOCKED, a transfer with eop=1 SHALL return to IDLE and set rr_ptr = (lock_idx+1) mod NUM_IN.
REQ-026 In LOCKED, a deasserted i_val[lock_idx] (bubble) SHALL hold the lock. o_axi.val SHALL be 0 during the bubble.
REQ-027 The sop value SHALL be forwarded without being checked. Framing errors SHALL pass through unmodified on err.
REQ-028 If no requester has val=1 in IDLE, o_grant SHALL be 0 and rr_ptr SHALL hold.
REQ-029 In IDLE, the grant SHALL be allowed to change between cycles while o_axi.rdy=0; a packet is committed only by a transfer.

Reset
REQ-030 While i_rst=1, o_rdy_in, o_axi.val, o_grant and o_lock SHALL all be 0.
REQ-031 Reset SHALL set the state to IDLE, rr_ptr to 0 and lock_idx to 0, including when reset arrives mid-packet.
REQ-032 The first cycle after i_rst falls SHALL arbitrate normally from rr_ptr=0.

Verification
REQ-033 Fairness: NUM_IN=4, all i_val=1, every beat has sop=eop=1, o_axi.rdy=1 -> grants 0,1,2,3,0,1 on consecutive cycles.
REQ-034 Lock: req1 sends a 3-beat packet while req0 and req2 are also valid, rr_ptr=1 -> o_grant=0010 for 3 transfers with o_lock=1 during beats 2-3, then next grant is req2.
REQ-035 Backpressure and bubble: o_axi.rdy=0 for 2 cycles mid-packet, then i_val of the owner drops for 1 cycle -> no beat is lost or duplicated, grant is unchanged, and o_axi.val=0 during the bubble.
REQ-036 Reset mid-packet: assert i_rst after beat 2 of a 4-beat packet from req3 -> next cycle o_lock=0 and rr_ptr=0; with req0 and req3 both valid, req0 wins.
REQ-037 Sparse: only req2 valid, single-beat packets, rr_ptr=3 -> req2 is granted each beat and rr_ptr becomes 3 after each transfer.
REQ-038 Scoreboard: random val/rdy/lengths over 10k beats -> per-requester output order matches input order, and packets are never interleaved between sop and eop.
